// File: rtl/hram_pkg.sv
// Shared definitions for the HyperRAM arbiter: FSM state encoding,
// reset defaults for the controller command fields, and port widths.
package hram_pkg;

    // Arbiter FSM states; the encoding is fixed so it can be observed in debug.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    // Number of requester ports and byte-enable width of a data word.
    localparam int NPORT = 2;
    localparam int BE_W  = 4;

    // Values the controller command fields take out of reset.
    localparam logic [BE_W-1:0] DEF_BYTE_EN    = 4'hF;
    localparam int              DEF_NUM_DWORDS = 1;

endpackage

// File: rtl/hram_rr_pick.sv
// Two-port winner selection for the HyperRAM arbiter.
// Configuration macro HRAM_ARB_RR_EN:
//   defined   - round-robin: on contention the port that was not served last wins.
//   undefined - fixed priority: port 0 always wins on contention.
// A single requesting port always wins in either mode.
module hram_rr_pick
    import hram_pkg::*;
(
`ifdef HRAM_ARB_RR_EN
    input  logic             last_owner,
`endif
    input  logic [NPORT-1:0] req,
    output logic [NPORT-1:0] win
);

    // One-hot winner from the request vector (zero when nobody requests).
    always_comb begin
        win = '0;
`ifdef HRAM_ARB_RR_EN
        if (req == 2'b11) begin
            win = last_owner ? 2'b01 : 2'b10;
        end else begin
            win = req;
        end
`else
        if (req[0]) begin
            win = 2'b01;
        end else if (req[1]) begin
            win = 2'b10;
        end
`endif
    end

endmodule

// File: rtl/hram_arbiter.sv
// Shares one hyperram_controller between two requesters (port 0: UART command
// front end, port 1: DMA / pattern engine). Arbitrates, latches one command,
// pulses rd_req/wr_req into the controller, follows the controller's busy
// window and steers read data and the completion pulse back to the owner.
// Configuration macro HRAM_ARB_RR_EN selects round-robin arbitration
// (default build: fixed priority, port 0 wins on contention).
module hram_arbiter
    import hram_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int NDW_W     = 22,
    parameter int BUSY_WAIT = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_write,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    input  logic [3:0]        req_be0,
    input  logic [3:0]        req_be1,
    input  logic [NDW_W-1:0]  req_ndw0,
    input  logic [NDW_W-1:0]  req_ndw1,
    input  logic              req_mor0,
    input  logic              req_mor1,
    output logic [1:0]        rsp_rdy,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_done,
    output logic [1:0]        grant,
    output logic              hc_rd_req,
    output logic              hc_wr_req,
    output logic [ADDR_W-1:0] hc_addr,
    output logic [DATA_W-1:0] hc_wr_d,
    output logic [3:0]        hc_wr_byte_en,
    output logic [NDW_W-1:0]  hc_rd_num_dwords,
    output logic              hc_mem_or_reg,
    input  logic              hc_busy,
    input  logic              hc_rd_rdy,
    input  logic [DATA_W-1:0] hc_rd_d
);

    localparam int               CNT_W    = $clog2(BUSY_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_WAIT);
    localparam logic [NDW_W-1:0] NDW_RST  = NDW_W'(DEF_NUM_DWORDS);

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic [1:0]          rsp_done_q, rsp_done_d;
    logic                hc_rd_req_q, hc_rd_req_d;
    logic                hc_wr_req_q, hc_wr_req_d;
    logic [ADDR_W-1:0]   hc_addr_q, hc_addr_d;
    logic [DATA_W-1:0]   hc_wr_d_q, hc_wr_d_d;
    logic [BE_W-1:0]     hc_be_q, hc_be_d;
    logic [NDW_W-1:0]    hc_ndw_q, hc_ndw_d;
    logic                hc_mor_q, hc_mor_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef HRAM_ARB_RR_EN
    // Port favoured on the next contention; moves to the other port on completion.
    logic                rr_ptr_q, rr_ptr_d;
`endif

    logic [1:0]          win;
    logic                can_accept;
    logic                sel1;
    logic                op_write;
    logic                finish;

    hram_rr_pick u_pick (
`ifdef HRAM_ARB_RR_EN
        .last_owner (~rr_ptr_q),
`endif
        .req        (req_valid),
        .win        (win)
    );

    // A command can be taken only when idle, the controller is quiet and the
    // previous completion pulse has gone (guarantees one idle gap cycle).
    always_comb begin
        can_accept = (state_q == ST_IDLE) && (req_valid != 2'b00) &&
                     !hc_busy && (rsp_done_q == 2'b00);
        sel1       = win[1];
        op_write   = sel1 ? req_write[1] : req_write[0];
    end

    // Ready is combinational so the requester's fields are captured on the
    // same edge that completes the handshake; held low while in reset.
    assign req_ready = (rstn && can_accept) ? win : 2'b00;

    // Read data goes straight through to the current owner; dropped when idle.
    assign rsp_rdy  = hc_rd_rdy ? grant_q : 2'b00;
    assign rsp_data = (hc_rd_rdy && (grant_q != 2'b00)) ? hc_rd_d : '0;

    assign rsp_done         = rsp_done_q;
    assign grant            = grant_q;
    assign hc_rd_req        = hc_rd_req_q;
    assign hc_wr_req        = hc_wr_req_q;
    assign hc_addr          = hc_addr_q;
    assign hc_wr_d          = hc_wr_d_q;
    assign hc_wr_byte_en    = hc_be_q;
    assign hc_rd_num_dwords = hc_ndw_q;
    assign hc_mem_or_reg    = hc_mor_q;

    // Next-state, command latching, request pulses and completion tracking.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rsp_done_d  = 2'b00;
        hc_rd_req_d = 1'b0;
        hc_wr_req_d = 1'b0;
        hc_addr_d   = hc_addr_q;
        hc_wr_d_d   = hc_wr_d_q;
        hc_be_d     = hc_be_q;
        hc_ndw_d    = hc_ndw_q;
        hc_mor_d    = hc_mor_q;
        cnt_d       = cnt_q;
        finish      = 1'b0;
`ifdef HRAM_ARB_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (can_accept) begin
                    state_d     = ST_ISSUE;
                    grant_d     = win;
                    hc_addr_d   = sel1 ? req_addr1  : req_addr0;
                    hc_wr_d_d   = sel1 ? req_wdata1 : req_wdata0;
                    hc_be_d     = sel1 ? req_be1    : req_be0;
                    hc_ndw_d    = sel1 ? req_ndw1   : req_ndw0;
                    hc_mor_d    = sel1 ? req_mor1   : req_mor0;
                    // Pulse is registered so it is high exactly during ISSUE.
                    hc_wr_req_d = op_write;
                    hc_rd_req_d = !op_write;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (hc_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q <= CNT_W'(1)) begin
                    // Controller never reported busy: assume it already finished.
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!hc_busy) begin
                    finish = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (finish) begin
            state_d    = ST_IDLE;
            rsp_done_d = grant_q;
            grant_d    = 2'b00;
`ifdef HRAM_ARB_RR_EN
            rr_ptr_d   = grant_q[0];
`endif
        end
    end

    // State and output registers; reset returns to IDLE with default fields.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            grant_q     <= 2'b00;
            rsp_done_q  <= 2'b00;
            hc_rd_req_q <= 1'b0;
            hc_wr_req_q <= 1'b0;
            hc_addr_q   <= '0;
            hc_wr_d_q   <= '0;
            hc_be_q     <= DEF_BYTE_EN;
            hc_ndw_q    <= NDW_RST;
            hc_mor_q    <= 1'b0;
            cnt_q       <= '0;
`ifdef HRAM_ARB_RR_EN
            rr_ptr_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rsp_done_q  <= rsp_done_d;
            hc_rd_req_q <= hc_rd_req_d;
            hc_wr_req_q <= hc_wr_req_d;
            hc_addr_q   <= hc_addr_d;
            hc_wr_d_q   <= hc_wr_d_d;
            hc_be_q     <= hc_be_d;
            hc_ndw_q    <= hc_ndw_d;
            hc_mor_q    <= hc_mor_d;
            cnt_q       <= cnt_d;
`ifdef HRAM_ARB_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

endmodule

// File: doc/hram_arbiter.md
Name: hram_arbiter

Overview:
- Shares one hyperram_controller between two requester ports.
  - Port 0: UART command front end.
  - Port 1: second master, e.g. DMA/pattern engine.
- Arbitrates, latches one command, and pulses rd_req/wr_req into the controller.
- Tracks the controller's busy window and routes rd_d/rd_rdy back to the owning requester.
- Sits in top between the requesters and hyperram_controller, on hram_clk.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data word width
- NDW_W, 22, rd_num_dwords width
- BUSY_WAIT, 8, max cycles after issue for busy to rise before assuming completion

Ports:
- clk  in  1  hram_clk
- rstn  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester command valid (bit i = port i)
- req_ready  out  2  command accepted this cycle (one-hot or zero)
- req_write  in  2  1=write, 0=read, per port
- req_addr0/req_addr1  in  ADDR_W  address per port
- req_wdata0/req_wdata1  in  DATA_W  write data per port
- req_be0/req_be1  in  4  write byte enables per port
- req_ndw0/req_ndw1  in  NDW_W  read dword count per port
- req_mor0/req_mor1  in  1  mem_or_reg select per port
- rsp_rdy  out  2  read-data strobe to owning port
- rsp_data  out  DATA_W  read data (shared bus, valid with rsp_rdy)
- rsp_done  out  2  one-cycle completion pulse to owning port
- grant  out  2  current owner (one-hot, 0 when idle)
- hc_rd_req, hc_wr_req  out  1  one-cycle request pulses to controller
- hc_addr  out  ADDR_W
- hc_wr_d  out  DATA_W
- hc_wr_byte_en  out  4
- hc_rd_num_dwords  out  NDW_W
- hc_mem_or_reg  out  1
- hc_busy  in  1
- hc_rd_rdy  in  1
- hc_rd_d  in  DATA_W

Behaviour:
- Reset (rstn low, async):
  - State IDLE.
  - All outputs 0, except hc_wr_byte_en=4'hF and hc_rd_num_dwords=1.
  - Round-robin pointer = port 0.
- States: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
- IDLE:
  - If any req_valid and hc_busy=0, pick a winner and assert req_ready[winner] for exactly one cycle.
  - Latch that port's fields into the hc_* registers, set grant, go to ISSUE.
  - If hc_busy=1 (external/startup activity), stay in IDLE with no ready.
- ISSUE:
  - Drive hc_wr_req=1 (write) or hc_rd_req=1 (read) for exactly one cycle.
  - Load wait counter = BUSY_WAIT, go to WAIT_BUSY.
  - Request pulse occurs 1 cycle after req_ready.
- WAIT_BUSY:
  - hc_busy=1 -> WAIT_DONE.
  - Counter reaching 0 without busy -> treat as complete: go to IDLE, pulse rsp_done.
- WAIT_DONE:
  - Stay while hc_busy=1.
  - On hc_busy=0: pulse rsp_done[owner] for 1 cycle, clear grant, move pointer to the other port, go to IDLE.
- Read data: whenever hc_rd_rdy=1 and grant!=0, assert rsp_rdy[owner] the same cycle (combinational pass-through); rsp_data=hc_rd_d.
- hc_rd_rdy with grant=0: dropped, no rsp_rdy.
- Arbitration:
  - Round-robin; the port not served last wins when both are valid.
  - A single valid port wins regardless of pointer.
- hc_* address/data/enables hold their latched values until the next grant.
- Requester fields are sampled only in the req_ready cycle; later changes are ignored.
- Back-to-back operation: minimum 1 IDLE cycle between rsp_done and the next req_ready.
- Reset mid-operation returns to IDLE immediately. No rsp_done is issued. The controller is reset from the same rstn.

Optional Feature:
- HRAM_ARB_RR_EN
  - Defined: round-robin as above.
  - Undefined: fixed priority, port 0 always wins on contention; pointer logic removed.

Decomposition:
- Shared package hram_pkg holds:
  - state encoding constants ST_IDLE=0, ST_ISSUE=1, ST_WAIT_BUSY=2, ST_WAIT_DONE=3
  - default byte-enable 4'hF and default dword count 1
  - width constants.
- One natural sub-module: hram_rr_pick.
  - 2-bit request vector plus last-owner in, one-hot winner out.
  - Combinational; holds the HRAM_ARB_RR_EN conditional.

Test Plan:
- Port 0 write, addr=0x10, wdata=0xDEADBEEF, be=F:
  - req_ready[0] next cycle, hc_wr_req 1 cycle later with hc_addr=0x10.
  - Model busy high for 20 cycles -> rsp_done[0] one cycle after busy falls.
- Port 1 read, ndw=2: model gives two hc_rd_rdy pulses (0x11111111, 0x22222222) -> rsp_rdy[1] twice with matching rsp_data, rsp_done[1] after busy falls.
- Both ports valid continuously, RR_EN defined -> grants alternate 0,1,0,1. Undefined -> port 0 always granted.
- Controller never raises busy -> rsp_done after BUSY_WAIT=8 cycles, arbiter returns to IDLE.
- hc_busy=1 at idle with port 0 valid -> no req_ready until busy drops.
- rstn asserted during WAIT_DONE -> all outputs 0 asynchronously, no rsp_done; new request served normally after release.
